// File: rtl/pc_update_unit.sv
// Program-counter register and next-PC sequencer with stall hold and deferred redirect.
// Optional BRANCH_STATS_EN macro adds a saturating taken-redirect counter (branch_count).
module pc_update_unit #(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            dobranch,
   input  logic            dojump,
   input  logic [7:0]      offset,
   input  logic            busywait,
   output logic [PC_W-1:0] PC,
   output logic [PC_W-1:0] pc_plus4,
   output logic            redirect,
   output logic            pending
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] branch_count
`endif
);

   typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

   state_t            state;
   logic [PC_W-1:0]   pend_target;
   logic [PC_W-1:0]   target;
   logic              take;
   logic              load_redirect;

   assign pc_plus4 = PC + PC_W'(4);
   assign take     = dobranch | dojump;
   // Offset is a signed word count: sign-extend, then scale to bytes.
   assign target   = pc_plus4 + {{(PC_W-10){offset[7]}}, offset, 2'b00};

   always_comb begin
      load_redirect = 1'b0;
      case (state)
         RUN:       load_redirect = take & ~busywait;
         HOLD_PEND: load_redirect = ~busywait;
         default:   load_redirect = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         PC          <= RESET_PC;
         state       <= RUN;
         pend_target <= '0;
         redirect    <= 1'b0;
         pending     <= 1'b0;
      end else begin
         redirect <= load_redirect;
         case (state)
            RUN: begin
               if (!busywait) begin
                  PC <= take ? target : pc_plus4;
               end else if (take) begin
                  pend_target <= target;
                  state       <= HOLD_PEND;
                  pending     <= 1'b1;
               end else begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (!busywait) begin
                  PC    <= pc_plus4;
                  state <= RUN;
               end
            end
            HOLD_PEND: begin
               if (!busywait) begin
                  PC      <= pend_target;
                  state   <= RUN;
                  pending <= 1'b0;
               end
            end
            default: begin
               state   <= RUN;
               pending <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         branch_count <= '0;
      end else if (load_redirect && (branch_count != '1)) begin
         branch_count <= branch_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed scoreboard bench for pc_update_unit: expected PC/redirect/pending are queued
// when stimulus is applied and checked after the following clock edge.
module tb_pc_update_unit;

   logic        CLK;
   logic        RESET;
   logic        dobranch;
   logic        dojump;
   logic [7:0]  offset;
   logic        busywait;
   logic [31:0] PC;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        pending;
`ifdef BRANCH_STATS_EN
   logic [15:0] branch_count;
`endif

   int tests;
   int fails;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        red;
      logic        pend;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   pc_update_unit dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .dobranch (dobranch),
      .dojump   (dojump),
      .offset   (offset),
      .busywait (busywait),
      .PC       (PC),
      .pc_plus4 (pc_plus4),
      .redirect (redirect),
      .pending  (pending)
`ifdef BRANCH_STATS_EN
      ,
      .branch_count (branch_count)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check({e.tag, ".pc"},       PC,                e.pc);
         check({e.tag, ".pc_plus4"}, pc_plus4,          e.pc + 32'd4);
         check({e.tag, ".redirect"}, {31'd0, redirect}, {31'd0, e.red});
         check({e.tag, ".pending"},  {31'd0, pending},  {31'd0, e.pend});
`ifdef BRANCH_STATS_EN
         check({e.tag, ".count"},    {16'd0, branch_count}, {16'd0, e.cnt});
`endif
      end
   endtask

   // Queue the expectation for the coming edge, wait for it, then compare.
   task automatic step(input string tag, input logic [31:0] pc, input logic red,
                       input logic pend, input logic [15:0] cnt);
      sb.push_back('{tag, pc, red, pend, cnt});
      @(posedge CLK);
      #1;
      compare_head();
   endtask

   task automatic drive(input logic br, input logic jp, input logic [7:0] off, input logic bw);
      dobranch = br;
      dojump   = jp;
      offset   = off;
      busywait = bw;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      RESET = 1'b0;
      drive(0, 0, 8'h00, 0);
      #3;
      sb.push_back('{"reset", 32'h0, 1'b0, 1'b0, 16'd0});
      compare_head();
      #9 RESET = 1'b1;   // released between edges at t=12
      #4;                // t=16, just after first post-reset edge

      // The edge at t=15 already advanced PC to 4.
      sb.push_back('{"seq0", 32'h4, 1'b0, 1'b0, 16'd0});
      compare_head();
      step("seq1", 32'h8,  0, 0, 0);
      step("seq2", 32'hC,  0, 0, 0);
      step("seq3", 32'h10, 0, 0, 0);

      drive(1, 0, 8'h03, 0);
      step("beq_fwd", 32'h20, 1, 0, 1);
      drive(0, 0, 8'h00, 0);
      step("beq_after", 32'h24, 0, 0, 1);

      drive(0, 1, 8'hFA, 0);
      step("jmp_to10", 32'h10, 1, 0, 2);
      drive(0, 1, 8'hFE, 0);
      step("jmp_back", 32'h0C, 1, 0, 3);
      drive(1, 1, 8'hFE, 0);
      step("both_high", 32'h08, 1, 0, 4);
      drive(0, 1, 8'h0D, 0);
      step("jmp_to40", 32'h40, 1, 0, 5);

      drive(1, 0, 8'h01, 1);
      step("pend_enter", 32'h40, 0, 1, 5);
      drive(0, 1, 8'h7F, 1);
      step("pend_hold1", 32'h40, 0, 1, 5);
      drive(1, 0, 8'h80, 1);
      step("pend_hold2", 32'h40, 0, 1, 5);
      drive(0, 0, 8'h00, 0);
      step("pend_exit", 32'h48, 1, 0, 6);
      step("pend_after", 32'h4C, 0, 0, 6);

      drive(0, 1, 8'hFC, 0);
      step("jmp_to40b", 32'h40, 1, 0, 7);
      drive(0, 0, 8'h00, 1);
      step("hold_enter", 32'h40, 0, 0, 7);
      drive(1, 0, 8'h10, 1);
      step("hold_tog1", 32'h40, 0, 0, 7);
      drive(0, 0, 8'h10, 1);
      step("hold_tog2", 32'h40, 0, 0, 7);
      drive(1, 1, 8'h10, 1);
      step("hold_tog3", 32'h40, 0, 0, 7);
      drive(0, 0, 8'h00, 0);
      step("hold_exit", 32'h44, 0, 0, 7);

      drive(0, 0, 8'h00, 1);
      step("gap_hold", 32'h44, 0, 0, 7);
      drive(0, 0, 8'h00, 0);
      step("gap_run", 32'h48, 0, 0, 7);
      drive(1, 0, 8'h7F, 1);
      step("gap_pend", 32'h48, 0, 1, 7);
      drive(0, 0, 8'h00, 0);
      step("off_max", 32'h248, 1, 0, 8);
      drive(1, 0, 8'h80, 0);
      step("off_min", 32'h4C, 1, 0, 9);

      drive(0, 1, 8'h20, 1);
      step("rst_pend", 32'h4C, 0, 1, 9);
      #2 RESET = 1'b0;
      #1;
      sb.push_back('{"rst_mid", 32'h0, 1'b0, 1'b0, 16'd0});
      compare_head();
      drive(0, 0, 8'h00, 0);
      #2 RESET = 1'b1;
      step("rst_run", 32'h4, 0, 0, 0);
      drive(0, 1, 8'hFD, 0);
      step("wrap_to_top", 32'hFFFFFFFC, 1, 0, 1);
      drive(0, 0, 8'h00, 0);
      step("wrap_to_0", 32'h0, 0, 0, 1);
      step("wrap_after", 32'h4, 0, 0, 1);

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
